// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter: issue side (in_*) and result side (out_*).
interface pipelined_shifter_if #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [OPERAND_WIDTH-1:0]  In;
    logic [SHAMT_WIDTH-1:0]    ShAmt;
    logic [NUM_OPERATIONS-1:0] Oper;
    logic                      out_valid;
    logic                      out_ready;
    logic [OPERAND_WIDTH-1:0]  Out;
    logic                      out_zero;
    logic                      out_illegal;

    // Environment side: issues operations and consumes results
    modport master (
        output in_valid, In, ShAmt, Oper, out_ready,
        input  in_ready, out_valid, Out, out_zero, out_illegal
    );

    // Shifter side
    modport slave (
        input  in_valid, In, ShAmt, Oper, out_ready,
        output in_ready, out_valid, Out, out_zero, out_illegal
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined logarithmic barrel shifter/rotator. An input capture register is
// followed by one registered stage per shift-amount bit; stage k moves the
// data by 2**k when its amount bit is set. The whole pipe stalls as a unit
// when the result register is full and not accepted.

// One logarithmic stage: fixed-distance shift/rotate selected by opcode.
module pipelined_shifter_stage #(
    parameter int W    = 16,
    parameter int DIST = 1,
    parameter int OW   = 3
) (
    input  logic [W-1:0]  d,
    input  logic          en,
    input  logic [OW-1:0] op,
    output logic [W-1:0]  q
);
    localparam logic [OW-1:0] OP_ROL = OW'(0);
    localparam logic [OW-1:0] OP_SLL = OW'(1);
    localparam logic [OW-1:0] OP_SRA = OW'(2);
    localparam logic [OW-1:0] OP_SRL = OW'(3);
    localparam logic [OW-1:0] OP_ROR = OW'(4);

    // Move by DIST when enabled; illegal opcodes fall through unshifted.
    // SRA fill uses the current MSB, which is still the original sign bit.
    always_comb begin
        q = d;
        if (en) begin
            case (op)
                OP_ROL:  q = {d[W-DIST-1:0], d[W-1:W-DIST]};
                OP_SLL:  q = {d[W-DIST-1:0], {DIST{1'b0}}};
                OP_SRA:  q = {{DIST{d[W-1]}}, d[W-1:DIST]};
                OP_SRL:  q = {{DIST{1'b0}}, d[W-1:DIST]};
                OP_ROR:  q = {d[DIST-1:0], d[W-1:DIST]};
                default: q = d;
            endcase
        end
    end
endmodule

module pipelined_shifter #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_shifter_if.slave   bus
);
    localparam int S = SHAMT_WIDTH;
    localparam int W = OPERAND_WIDTH;
    localparam logic [NUM_OPERATIONS-1:0] OP_ROR = NUM_OPERATIONS'(4);

    // Register index 0 is the input capture; index k+1 holds the output of stage k.
    logic [S:0]                         vld_pipe;
    logic [S:0][W-1:0]                  dat_pipe;
    logic [S:0]                         ill_pipe;
    // Remaining amount bits: bit 0 of sh_pipe[k] is the bit stage k consumes.
    logic [S-1:0][S-1:0]                sh_pipe;
    logic [S-1:0][NUM_OPERATIONS-1:0]   op_pipe;
    logic [S-1:0][W-1:0]                dat_nxt;
    logic                               zero_q;
    logic                               stall;

    assign stall        = vld_pipe[S] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    for (genvar k = 0; k < S; k++) begin : g_stage
        pipelined_shifter_stage #(
            .W    (W),
            .DIST (1 << k),
            .OW   (NUM_OPERATIONS)
        ) u_stage (
            .d  (dat_pipe[k]),
            .en (sh_pipe[k][0]),
            .op (op_pipe[k]),
            .q  (dat_nxt[k])
        );
    end

    // Advance every register together unless the result is stalled; bubbles
    // travel with the data rather than being squeezed out.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
            ill_pipe <= '0;
            sh_pipe  <= '0;
            op_pipe  <= '0;
            zero_q   <= 1'b0;
        end else if (!stall) begin
            vld_pipe    <= {vld_pipe[S-1:0], bus.in_valid};
            ill_pipe    <= {ill_pipe[S-1:0], (bus.Oper > OP_ROR)};
            dat_pipe[0] <= bus.In;
            sh_pipe[0]  <= bus.ShAmt;
            op_pipe[0]  <= bus.Oper;
            for (int k = 0; k < S; k++) begin
                dat_pipe[k+1] <= dat_nxt[k];
            end
            for (int k = 1; k < S; k++) begin
                sh_pipe[k] <= sh_pipe[k-1] >> 1;
                op_pipe[k] <= op_pipe[k-1];
            end
            // Zero flag is registered alongside the result so it resets to 0.
            zero_q <= (dat_nxt[S-1] == '0);
        end
    end

    assign bus.out_valid   = vld_pipe[S];
    assign bus.Out         = dat_pipe[S];
    assign bus.out_zero    = zero_q;
    assign bus.out_illegal = ill_pipe[S];
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: 16-bit instance for the main
// scenarios, 32-bit instance for the wider parameter set.
module tb_pipelined_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] out;
        logic        zero;
        logic        ill;
    } exp_t;

    pipelined_shifter_if #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4), .NUM_OPERATIONS(3)) ia();
    pipelined_shifter_if #(.OPERAND_WIDTH(32), .SHAMT_WIDTH(5), .NUM_OPERATIONS(3)) ib();

    pipelined_shifter #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4), .NUM_OPERATIONS(3)) dut_a (
        .clk (clk), .rst (rst), .bus (ia)
    );
    pipelined_shifter #(.OPERAND_WIDTH(32), .SHAMT_WIDTH(5), .NUM_OPERATIONS(3)) dut_b (
        .clk (clk), .rst (rst), .bus (ib)
    );

    // Reference: plain arithmetic on a w-bit value.
    function automatic exp_t model(int w, logic [63:0] x_in, int s, int op);
        logic [63:0] m, x, r;
        exp_t e;
        m = (64'd1 << w) - 64'd1;
        x = x_in & m;
        case (op)
            0: r = ((x << s) | (x >> (w - s))) & m;
            1: r = (x << s) & m;
            2: r = (x >> s) | ((((x >> (w - 1)) & 64'd1) != 0) ? (m & ~(m >> s)) : 64'd0);
            3: r = x >> s;
            4: r = ((x >> s) | (x << (w - s))) & m;
            default: r = x;
        endcase
        e.out  = r[31:0];
        e.zero = (r == 64'd0);
        e.ill  = (op > 4);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ia.in_valid = 1'b0; ia.In = '0; ia.ShAmt = '0; ia.Oper = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.In = '0; ib.ShAmt = '0; ib.Oper = '0; ib.out_ready = 1'b1;
        repeat (2) tick();
        n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ia.out_valid); end
        n_cmp++; if (ia.Out !== 16'h0) begin n_err++; $display("FAIL reset_out got %h want 0000", ia.Out); end
        n_cmp++; if (ia.out_zero !== 1'b0) begin n_err++; $display("FAIL reset_out_zero got %b want 0", ia.out_zero); end
        n_cmp++; if (ia.out_illegal !== 1'b0) begin n_err++; $display("FAIL reset_out_illegal got %b want 0", ia.out_illegal); end
        n_cmp++; if (ib.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid32 got %b want 0", ib.out_valid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (ia.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", ia.in_ready); end
        tick();
    endtask

    // Directed single ops with expected values written out by hand.
    task automatic test_directed();
        logic [15:0] din[7]  = '{16'h8001, 16'h00FF, 16'h8000, 16'h8000, 16'h0001, 16'h8000, 16'h1234};
        int          sh[7]   = '{1, 4, 15, 15, 4, 1, 5};
        int          op[7]   = '{0, 1, 2, 3, 4, 1, 6};
        logic [15:0] dexp[7] = '{16'h0003, 16'h0FF0, 16'hFFFF, 16'h0001, 16'h1000, 16'h0000, 16'h1234};
        logic        zexp[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        iexp[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ia.in_valid = 1'b1; ia.In = din[i]; ia.ShAmt = 4'(sh[i]); ia.Oper = 3'(op[i]);
            tick();
            ia.in_valid = 1'b0;
            lat = 0;
            while (ia.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
            n_cmp++; if (lat != 4) begin n_err++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
            n_cmp++; if (ia.Out !== dexp[i]) begin n_err++; $display("FAIL dir%0d_out got %h want %h", i, ia.Out, dexp[i]); end
            n_cmp++; if (ia.out_zero !== zexp[i]) begin n_err++; $display("FAIL dir%0d_zero got %b want %b", i, ia.out_zero, zexp[i]); end
            n_cmp++; if (ia.out_illegal !== iexp[i]) begin n_err++; $display("FAIL dir%0d_illegal got %b want %b", i, ia.out_illegal, iexp[i]); end
            tick();
        end
    endtask

    // ROL 0x0001 by 0..7 on consecutive cycles; results on consecutive cycles.
    task automatic test_back_to_back();
        logic [15:0] e;
        ia.out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c < 8) begin
                ia.in_valid = 1'b1; ia.In = 16'h0001; ia.ShAmt = 4'(c); ia.Oper = 3'd0;
            end else begin
                ia.in_valid = 1'b0;
            end
            tick();
            if (c < 4) begin
                n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early_valid c%0d got %b want 0", c, ia.out_valid); end
            end else if (c < 12) begin
                e = 16'h0001;
                e = e << (c - 4);
                n_cmp++; if (ia.out_valid !== 1'b1 || ia.Out !== e) begin
                    n_err++; $display("FAIL b2b_out c%0d got v=%b %h want v=1 %h", c, ia.out_valid, ia.Out, e);
                end
            end else begin
                n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail_valid got %b want 0", ia.out_valid); end
            end
        end
    endtask

    // Streaming with a fixed 3-cycle output stall while the pipe is full.
    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        int nsent = 0, nrecv = 0, s, o;
        bit pend = 0, stalled, stall_prev = 0;
        logic [15:0] x, out_prev = '0;
        for (int c = 0; c < 80 && nrecv < 8; c++) begin
            if (!pend && nsent < 8) begin
                x = 16'($urandom); s = $urandom_range(0, 15); o = $urandom_range(0, 4);
                pend = 1;
            end
            ia.in_valid = pend; ia.In = x; ia.ShAmt = 4'(s); ia.Oper = 3'(o);
            ia.out_ready = !(c >= 6 && c <= 8);
            @(negedge clk);
            stalled = ia.out_valid && !ia.out_ready;
            n_cmp++; if (ia.in_ready !== !stalled) begin n_err++; $display("FAIL bp_in_ready c%0d got %b want %b", c, ia.in_ready, !stalled); end
            if (c >= 6 && c <= 8) begin
                n_cmp++; if (ia.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low c%0d got %b want 0", c, ia.in_ready); end
            end
            if (stall_prev) begin
                n_cmp++; if (ia.out_valid !== 1'b1 || ia.Out !== out_prev) begin
                    n_err++; $display("FAIL bp_hold c%0d got v=%b %h want v=1 %h", c, ia.out_valid, ia.Out, out_prev);
                end
            end
            if (ia.out_valid && ia.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL bp_extra_result got %h want none", ia.Out); end
                else begin
                    e = q.pop_front();
                    if (ia.Out !== e.out[15:0]) begin n_err++; $display("FAIL bp_out #%0d got %h want %h", nrecv, ia.Out, e.out[15:0]); end
                end
                nrecv++;
            end
            if (ia.in_valid && ia.in_ready) begin
                q.push_back(model(16, 64'(x), s, o));
                nsent++; pend = 0;
            end
            stall_prev = stalled; out_prev = ia.Out;
            tick();
        end
        ia.in_valid = 1'b0; ia.out_ready = 1'b1;
        n_cmp++; if (nrecv != 8) begin n_err++; $display("FAIL bp_count got %0d want 8", nrecv); end
        repeat (6) tick();
        n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", ia.out_valid); end
    endtask

    // Random ops (illegal opcodes included) under random backpressure.
    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int nsent = 0, nrecv = 0, s, o;
        bit pend = 0, stalled, stall_prev = 0;
        logic [15:0] x, out_prev = '0;
        logic zp = 0, ip = 0;
        for (int c = 0; c < 2000 && nrecv < 60; c++) begin
            if (!pend && nsent < 60 && $urandom_range(0, 3) != 0) begin
                x = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
                s = $urandom_range(0, 15); o = $urandom_range(0, 7);
                pend = 1;
            end
            ia.in_valid = pend; ia.In = x; ia.ShAmt = 4'(s); ia.Oper = 3'(o);
            ia.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            stalled = ia.out_valid && !ia.out_ready;
            n_cmp++; if (ia.in_ready !== !stalled) begin n_err++; $display("FAIL rnd_in_ready c%0d got %b want %b", c, ia.in_ready, !stalled); end
            if (stall_prev) begin
                n_cmp++; if (ia.out_valid !== 1'b1 || ia.Out !== out_prev || ia.out_zero !== zp || ia.out_illegal !== ip) begin
                    n_err++; $display("FAIL rnd_hold c%0d got v=%b %h z=%b i=%b want v=1 %h z=%b i=%b",
                                      c, ia.out_valid, ia.Out, ia.out_zero, ia.out_illegal, out_prev, zp, ip);
                end
            end
            if (ia.out_valid && ia.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL rnd_extra_result got %h want none", ia.Out); end
                else begin
                    e = q.pop_front();
                    if (ia.Out !== e.out[15:0] || ia.out_zero !== e.zero || ia.out_illegal !== e.ill) begin
                        n_err++; $display("FAIL rnd_out #%0d got %h z=%b i=%b want %h z=%b i=%b",
                                          nrecv, ia.Out, ia.out_zero, ia.out_illegal, e.out[15:0], e.zero, e.ill);
                    end
                end
                nrecv++;
            end
            if (ia.in_valid && ia.in_ready) begin
                q.push_back(model(16, 64'(x), s, o));
                nsent++; pend = 0;
            end
            stall_prev = stalled; out_prev = ia.Out; zp = ia.out_zero; ip = ia.out_illegal;
            tick();
        end
        ia.in_valid = 1'b0; ia.out_ready = 1'b1;
        n_cmp++; if (nrecv != 60) begin n_err++; $display("FAIL rnd_count got %0d want 60", nrecv); end
        repeat (6) tick();
    endtask

    // Three ops in flight, one reset cycle: nothing emerges, next op is normal.
    task automatic test_reset_midflight();
        exp_t e;
        int lat, seen;
        logic [15:0] x;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ia.in_valid = 1'b1; ia.In = 16'($urandom) | 16'h0001; ia.ShAmt = 4'(i); ia.Oper = 3'd0;
            tick();
        end
        ia.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", ia.out_valid); end
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ia.out_valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_rst_ghost got %0d results want 0", seen); end
        x = 16'($urandom);
        e = model(16, 64'(x), 7, 3);
        ia.in_valid = 1'b1; ia.In = x; ia.ShAmt = 4'd7; ia.Oper = 3'd3;
        tick();
        ia.in_valid = 1'b0;
        lat = 0;
        while (ia.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL mid_post_latency got %0d want 4", lat); end
        n_cmp++; if (ia.Out !== e.out[15:0]) begin n_err++; $display("FAIL mid_post_out got %h want %h", ia.Out, e.out[15:0]); end
        tick();
    endtask

    // 32-bit instance: two directed cases then random ops, latency 5.
    task automatic test_param32();
        logic [31:0] din[2]  = '{32'h80000000, 32'h00000001};
        int          sh[2]   = '{31, 1};
        int          op[2]   = '{2, 4};
        logic [31:0] dexp[2] = '{32'hFFFFFFFF, 32'h80000000};
        logic [31:0] x, want;
        int lat, s, o;
        exp_t e;
        ib.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 2) begin
                x = din[i]; s = sh[i]; o = op[i]; want = dexp[i];
            end else begin
                x = $urandom; s = $urandom_range(0, 31); o = $urandom_range(0, 7);
                e = model(32, 64'(x), s, o); want = e.out;
            end
            ib.in_valid = 1'b1; ib.In = x; ib.ShAmt = 5'(s); ib.Oper = 3'(o);
            tick();
            ib.in_valid = 1'b0;
            lat = 0;
            while (ib.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
            n_cmp++; if (lat != 5) begin n_err++; $display("FAIL w32_%0d_latency got %0d want 5", i, lat); end
            n_cmp++; if (ib.Out !== want) begin n_err++; $display("FAIL w32_%0d_out got %h want %h", i, ib.Out, want); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_param32();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the combinational barrel shifter.
- Same operations, plus rotate right and illegal-opcode flagging.
- Width and shift range are generic. One logarithmic stage is registered per shift-amount bit.
- Valid/ready handshake on both sides, full backpressure. Sits between the decode/issue stage and the ALU result mux of the multi-cycle datapath.

Parameters:
- OPERAND_WIDTH, 16: data width in bits. Must equal 2**SHAMT_WIDTH.
- SHAMT_WIDTH, 4: shift-amount width. Also sets the pipeline depth (number of stages).
- NUM_OPERATIONS, 3: opcode width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept input this cycle
- In  input  OPERAND_WIDTH  operand
- ShAmt  input  SHAMT_WIDTH  shift/rotate amount, unsigned
- Oper  input  NUM_OPERATIONS  operation select
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- Out  output  OPERAND_WIDTH  result
- out_zero  output  1  Out == 0
- out_illegal  output  1  opcode was illegal; Out equals the unmodified operand

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Sampled only on the rising edge of clk.
- Reset values: every stage valid bit = 0; out_valid = 0; Out = 0; out_zero = 0; out_illegal = 0.
- in_ready is combinational and is not a reset value; after reset it reads 1.
- Opcodes:
  - 000 rotate left
  - 001 shift left logical (zero fill)
  - 010 shift right arithmetic (fill with operand MSB)
  - 011 shift right logical (zero fill)
  - 100 rotate right
  - 101..111 illegal: data passes unshifted and out_illegal = 1
- Pipeline: stages 0..SHAMT_WIDTH-1.
  - Stage k conditionally shifts or rotates by 2**k when ShAmt bit k is 1.
  - Each stage register holds: valid, data, remaining ShAmt bits, Oper, illegal flag.
  - SRA fill comes from the current data MSB at each stage; this equals the original sign bit.
  - Out, out_zero and out_illegal are driven from the final stage register.
- Latency: exactly SHAMT_WIDTH cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+SHAMT_WIDTH, provided there is no stall.
- Throughput: one result per cycle.
- Handshake:
  - stall = out_valid & ~out_ready. in_ready = ~stall.
  - When stall = 1, every stage register holds its value.
  - When stall = 0, all stages advance. Stage 0 loads in_valid and the input fields.
  - Bubbles are not compressed.
  - Out, out_zero and out_illegal hold stable while out_valid & ~out_ready.
  - A transfer occurs on the edge where out_valid & out_ready.
- ShAmt = 0: result equals In for every legal opcode.
- Width rules:
  - Shifts never produce values outside OPERAND_WIDTH.
  - Shift by OPERAND_WIDTH-1 is the maximum.
  - Rotate is modulo OPERAND_WIDTH by construction.
- Simultaneous events:
  - Input accept and output transfer in the same cycle are legal; the pipeline advances once.
  - in_valid while in_ready = 0: input is ignored, not queued. The source must hold its request.
- Reset mid-operation: all in-flight transactions are discarded. out_valid = 0 on the cycle after reset is asserted; no partial result emerges.
- Outputs while out_valid = 0 are don't-care for checking. The implementation drives stage data regardless.

Test Plan:
- Reset then single ops, ready held high, 16-bit defaults:
  - ROL 0x8001 by 1 -> Out 0x0003, out_valid exactly 4 cycles after accept.
  - SLL 0x00FF by 4 -> 0x0FF0.
  - SRA 0x8000 by 15 -> 0xFFFF.
  - SRL 0x8000 by 15 -> 0x0001.
  - ROR 0x0001 by 4 -> 0x1000.
- Back-to-back streaming: 8 consecutive ROL ops with ShAmt 0..7 on 0x0001 -> outputs 0x0001, 0x0002 ... 0x0080 in order on 8 consecutive cycles.
- Backpressure: fill pipeline, drop out_ready for 3 cycles -> in_ready = 0, Out/out_valid stable, no loss or duplication; release -> remaining results in order.
- Flags:
  - SLL 0x8000 by 1 -> Out 0x0000, out_zero = 1.
  - Oper 110 on 0x1234, ShAmt 5 -> Out 0x1234, out_illegal = 1.
- Reset mid-flight: 3 ops in pipe, assert rst one cycle -> out_valid = 0 next cycle; none of the 3 results ever appears; next op after reset has normal 4-cycle latency.
- Parameter sweep: OPERAND_WIDTH=32, SHAMT_WIDTH=5; SRA 0x80000000 by 31 -> 0xFFFFFFFF with 5-cycle latency; ROR 0x00000001 by 1 -> 0x80000000.
